button_press_ctrl: RTL and testbench
====================================

Name: button_press_ctrl

Overview:
- Consumes the debounced, clock-synchronous button level produced by the debounce stage. Turns that level into single-cycle user-intent events: press, release, long-press and auto-repeat.
- Sits between each debounced alarm-clock button (set hour, set minute, alarm) and the time/alarm setting logic.
- `o_Step` gives the setting logic one increment per press, then fast increments while the button stays held.

Parameters:
- LONG_TICKS, 500, number of i_Tick pulses the button must be held before o_Long fires (≥1).
- REPEAT_TICKS, 100, i_Tick pulses between o_Repeat pulses once long-held (≥1).
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = o_Repeat never asserts.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Tick  input  1  single-cycle time-base enable (e.g. 1 kHz strobe).
- i_Button  input  1  debounced button level, synchronous to i_Clk.
- o_Press  output  1  one-cycle pulse on button press.
- o_Release  output  1  one-cycle pulse on button release.
- o_Long  output  1  one-cycle pulse when hold reaches LONG_TICKS.
- o_Repeat  output  1  one-cycle pulse every REPEAT_TICKS after o_Long.
- o_Step  output  1  o_Press | o_Repeat (registered).
- o_Held  output  1  level: button currently registered as held.

Behaviour:
- Reset: the block resets asynchronously when i_Reset is high. All outputs are 0, state = IDLE, counter = 0, r_Btn_Prev = 0.
- All outputs are registered. Pulse outputs are high for exactly one i_Clk cycle.
- Edge detection: r_Btn_Prev samples i_Button every cycle.
  - rise = i_Button & ~r_Btn_Prev
  - fall = ~i_Button & r_Btn_Prev
- FSM states: IDLE, HOLD, REPEAT.
- IDLE:
  - On rise: next state HOLD, counter cleared to 0, o_Press = 1 and o_Step = 1 in the following cycle (latency 1 clock from the i_Button edge).
  - No other event is possible in IDLE.
- HOLD:
  - o_Held = 1.
  - On i_Tick: counter += 1.
  - On i_Tick with counter == LONG_TICKS-1: o_Long pulse, counter cleared, next state REPEAT.
- REPEAT:
  - o_Held = 1.
  - On i_Tick: counter += 1.
  - On i_Tick with counter == REPEAT_TICKS-1: counter cleared; if REPEAT_EN, o_Repeat and o_Step pulse.
  - Stays in REPEAT until release.
- Release: fall in HOLD or REPEAT returns to IDLE, pulses o_Release, clears counter, drops o_Held. Release has priority over a coincident long/repeat tick, so no o_Long or o_Repeat is issued that cycle.
- i_Tick in IDLE is ignored.
- Counter width: $clog2 of max(LONG_TICKS, REPEAT_TICKS) + 1 bits, saturation not needed.
- Reset mid-hold: the block returns to IDLE. Because r_Btn_Prev resets to 0, a button still held when reset deasserts produces a fresh o_Press on the first clock after deassertion, and the hold timing restarts.
- Minimum press: a 1-cycle high on i_Button gives o_Press followed by o_Release one cycle later. Both are valid.
- o_Press and o_Repeat are never simultaneous, so o_Step is always a single-cycle pulse.

Decomposition:
- Shared package, alarm_pkg:
  - state encoding localparams (IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2);
  - default timing constants: LONG_TICKS_DEFAULT = 500, REPEAT_TICKS_DEFAULT = 100, TICK_HZ = 1000.
- Optional sub-module edge_detect: 1-bit registered rise/fall detector. It is reusable by the alarm-arm switch logic.
- The FSM and counter remain in button_press_ctrl.

Test Plan:
- Single press (LONG_TICKS=4, REPEAT_TICKS=2, i_Tick every 4 clocks): i_Button high for 3 ticks then low.
  - Required: exactly one o_Press and one o_Step, one cycle after the rise.
  - Required: o_Release one cycle after the fall; no o_Long.
- Long hold (same parameters): hold 10 ticks.
  - Required: o_Long on the cycle after the 4th tick.
  - Required: o_Repeat/o_Step after the 6th, 8th and 10th ticks (3 repeats); o_Held high throughout.
- REPEAT_EN=0 long hold: the same 10-tick hold gives o_Long once and zero o_Repeat pulses; o_Step pulses only once.
- Release coincident with 4th tick: fall and the 4th i_Tick in the same cycle.
  - Required: o_Release pulses, o_Long stays 0, state returns to IDLE.
- Async reset mid-REPEAT with button held: assert i_Reset between clock edges.
  - Required: all outputs 0 immediately.
  - Required: after deassertion, o_Press on the first clock, and o_Long again after 4 further ticks.
- Glitch-free minimum press: 1-cycle i_Button pulse gives o_Press at cycle t+1 and o_Release at t+2. Idle i_Tick activity produces no outputs.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared constants for the alarm-clock button path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the press-controller state encoding and the default timing constants
// used by the alarm-clock button path.
package alarm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t HOLD   = 2'd1;
    localparam state_t REPEAT = 2'd2;

    // Default timing, in i_Tick pulses (TICK_HZ strobe => 500 ms long-press,
    // 100 ms auto-repeat period).
    localparam int LONG_TICKS_DEFAULT   = 500;
    localparam int REPEAT_TICKS_DEFAULT = 100;
    localparam int TICK_HZ              = 1000;

endpackage

// File: rtl/button_press_ctrl_if.sv
// Bundle of button-side inputs and user-intent event outputs.
// Latency: n/a (wiring only).
// Backpressure: none; events are fire-and-forget pulses.
//
// Signals:
//   i_Tick     time-base strobe into the controller
//   i_Button   debounced button level into the controller
//   o_Press, o_Release, o_Long, o_Repeat, o_Step   one-cycle event pulses
//   o_Held     level, button registered as held
// master drives the inputs and observes events; slave is the controller.
interface button_press_ctrl_if;

    logic i_Tick;
    logic i_Button;
    logic o_Press;
    logic o_Release;
    logic o_Long;
    logic o_Repeat;
    logic o_Step;
    logic o_Held;

    modport master (
        output i_Tick, i_Button,
        input  o_Press, o_Release, o_Long, o_Repeat, o_Step, o_Held
    );

    modport slave (
        input  i_Tick, i_Button,
        output o_Press, o_Release, o_Long, o_Repeat, o_Step, o_Held
    );

endinterface

// File: rtl/edge_detect.sv
// Single-bit rise/fall detector against a registered copy of the input.
// Latency: combinational from i_Sig (edges compare against last cycle's value).
// Backpressure: none.
//
// Ports:
//   i_Clk, i_Reset   clock, async active-high reset (previous value resets to 0)
//   i_Sig            synchronous level to watch
//   o_Rise, o_Fall   high in the cycle i_Sig differs from its previous sample
module edge_detect (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sig,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_Sig_Prev;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Sig_Prev <= 1'b0;
        end else begin
            r_Sig_Prev <= i_Sig;
        end
    end

    assign o_Rise = i_Sig & ~r_Sig_Prev;
    assign o_Fall = ~i_Sig & r_Sig_Prev;

endmodule

// File: rtl/button_press_ctrl.sv
// Turns a debounced button level into press/release/long/repeat/step events.
// Latency: every output is registered, 1 clock after the causing edge or tick.
// Backpressure: none; pulses are one cycle wide and cannot be stalled.
//
// Ports:
//   i_Clk, i_Reset   clock, async active-high reset
//   io_Btn           slave side of button_press_ctrl_if (i_Tick, i_Button in;
//                    o_Press, o_Release, o_Long, o_Repeat, o_Step, o_Held out)
module button_press_ctrl
    import alarm_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DEFAULT,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEFAULT,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    button_press_ctrl_if.slave  io_Btn
);

    localparam int CNT_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_t           r_State;
    state_t           w_State_Nxt;
    logic [CNT_W-1:0] r_Cnt;
    logic [CNT_W-1:0] w_Cnt_Nxt;

    logic w_Rise;
    logic w_Fall;

    logic w_Press;
    logic w_Release;
    logic w_Long;
    logic w_Repeat;

    logic r_Press;
    logic r_Release;
    logic r_Long;
    logic r_Repeat;
    logic r_Step;
    logic r_Held;

    edge_detect u_edge (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sig   (io_Btn.i_Button),
        .o_Rise  (w_Rise),
        .o_Fall  (w_Fall)
    );

    // State register
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= IDLE;
            r_Cnt   <= '0;
        end else begin
            r_State <= w_State_Nxt;
            r_Cnt   <= w_Cnt_Nxt;
        end
    end

    // Next-state and counter. Release is checked before the tick so a fall
    // coinciding with the terminal tick never produces a long/repeat event.
    always_comb begin
        w_State_Nxt = r_State;
        w_Cnt_Nxt   = r_Cnt;
        case (r_State)
            IDLE: begin
                if (w_Rise) begin
                    w_State_Nxt = HOLD;
                    w_Cnt_Nxt   = '0;
                end
            end
            HOLD: begin
                if (w_Fall) begin
                    w_State_Nxt = IDLE;
                    w_Cnt_Nxt   = '0;
                end else if (io_Btn.i_Tick) begin
                    if (r_Cnt == LONG_LAST) begin
                        w_State_Nxt = REPEAT;
                        w_Cnt_Nxt   = '0;
                    end else begin
                        w_Cnt_Nxt = r_Cnt + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (w_Fall) begin
                    w_State_Nxt = IDLE;
                    w_Cnt_Nxt   = '0;
                end else if (io_Btn.i_Tick) begin
                    if (r_Cnt == REPEAT_LAST) begin
                        w_Cnt_Nxt = '0;
                    end else begin
                        w_Cnt_Nxt = r_Cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_State_Nxt = IDLE;
                w_Cnt_Nxt   = '0;
            end
        endcase
    end

    // Event decode, registered below
    always_comb begin
        w_Press   = 1'b0;
        w_Release = 1'b0;
        w_Long    = 1'b0;
        w_Repeat  = 1'b0;
        case (r_State)
            IDLE: begin
                w_Press = w_Rise;
            end
            HOLD: begin
                w_Release = w_Fall;
                w_Long    = ~w_Fall & io_Btn.i_Tick & (r_Cnt == LONG_LAST);
            end
            REPEAT: begin
                w_Release = w_Fall;
                w_Repeat  = REPEAT_EN & ~w_Fall & io_Btn.i_Tick & (r_Cnt == REPEAT_LAST);
            end
            default: ;
        endcase
    end

    // Press only comes from IDLE and repeat only from REPEAT, so o_Step can
    // never merge two adjacent events into a wider pulse.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Press   <= 1'b0;
            r_Release <= 1'b0;
            r_Long    <= 1'b0;
            r_Repeat  <= 1'b0;
            r_Step    <= 1'b0;
            r_Held    <= 1'b0;
        end else begin
            r_Press   <= w_Press;
            r_Release <= w_Release;
            r_Long    <= w_Long;
            r_Repeat  <= w_Repeat;
            r_Step    <= w_Press | w_Repeat;
            r_Held    <= (w_State_Nxt != IDLE);
        end
    end

    assign io_Btn.o_Press   = r_Press;
    assign io_Btn.o_Release = r_Release;
    assign io_Btn.o_Long    = r_Long;
    assign io_Btn.o_Repeat  = r_Repeat;
    assign io_Btn.o_Step    = r_Step;
    assign io_Btn.o_Held    = r_Held;

endmodule

// File: tb/tb_button_press_ctrl.sv
// Bench for button_press_ctrl: two instances (auto-repeat on / off) driven with
// the same button and tick stimulus, checked cycle by cycle against a
// tick-counting reference, plus per-scenario event counts.
module tb_button_press_ctrl;

    localparam int LT = 4;
    localparam int RT = 2;

    logic clk;
    logic rst;
    logic btn;
    logic tick;

    button_press_ctrl_if bus_a ();
    button_press_ctrl_if bus_b ();

    assign bus_a.i_Button = btn;
    assign bus_a.i_Tick   = tick;
    assign bus_b.i_Button = btn;
    assign bus_b.i_Tick   = tick;

    button_press_ctrl #(.LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b1)) dut_a (
        .i_Clk   (clk),
        .i_Reset (rst),
        .io_Btn  (bus_a.slave)
    );

    button_press_ctrl #(.LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b0)) dut_b (
        .i_Clk   (clk),
        .i_Reset (rst),
        .io_Btn  (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // {press, release, long, repeat, step, held} for a then b
    function automatic logic [11:0] outs();
        return {bus_a.o_Press, bus_a.o_Release, bus_a.o_Long, bus_a.o_Repeat, bus_a.o_Step, bus_a.o_Held,
                bus_b.o_Press, bus_b.o_Release, bus_b.o_Long, bus_b.o_Repeat, bus_b.o_Step, bus_b.o_Held};
    endfunction

    // Reference: counts ticks since the press; long at LT, repeat every RT after.
    bit m_prev;
    bit m_held;
    int m_th;
    logic [11:0] sb[$];

    task automatic model_reset();
        m_prev = 1'b0;
        m_held = 1'b0;
        m_th   = 0;
    endtask

    // Call at a negedge; returns at the following negedge.
    task automatic drive(input bit b, input bit t);
        bit rise, fall, pr, rl, lg, rp;
        btn  = b;
        tick = t;
        rise = b && !m_prev;
        fall = !b && m_prev;
        pr = 0; rl = 0; lg = 0; rp = 0;
        if (!m_held && rise) begin
            pr = 1; m_held = 1; m_th = 0;
        end else if (m_held && fall) begin
            rl = 1; m_held = 0;
        end else if (m_held && t) begin
            m_th++;
            lg = (m_th == LT);
            rp = (m_th > LT) && (((m_th - LT) % RT) == 0);
        end
        m_prev = b;
        sb.push_back({pr, rl, lg, rp, pr | rp, m_held, pr, rl, lg, 1'b0, pr, m_held});
        @(negedge clk);
    endtask

    task automatic hold_ticks(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            drive(b, 1'b0);
            drive(b, 1'b0);
            drive(b, 1'b0);
            drive(b, 1'b1);
        end
    endtask

    int a_press, a_rel, a_long, a_rep, a_step, b_long, b_rep, b_step;

    task automatic clr_counts();
        a_press = 0; a_rel = 0; a_long = 0; a_rep = 0; a_step = 0;
        b_long = 0; b_rep = 0; b_step = 0;
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (!rst) begin
            a_press += int'(bus_a.o_Press);
            a_rel   += int'(bus_a.o_Release);
            a_long  += int'(bus_a.o_Long);
            a_rep   += int'(bus_a.o_Repeat);
            a_step  += int'(bus_a.o_Step);
            b_long  += int'(bus_b.o_Long);
            b_rep   += int'(bus_b.o_Repeat);
            b_step  += int'(bus_b.o_Step);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cycle_outs", 32'(outs()), 32'(e));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        btn  = 1'b0;
        tick = 1'b0;
        model_reset();
        clr_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle ticks produce nothing
        clr_counts();
        hold_ticks(1'b0, 3);
        chk("idle_events", 32'(a_press + a_rel + a_long + a_rep + a_step + b_step), 32'd0);

        // Single press, 3 ticks, release
        clr_counts();
        drive(1'b1, 1'b0);
        hold_ticks(1'b1, 3);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("single_press", 32'(a_press), 32'd1);
        chk("single_step",  32'(a_step),  32'd1);
        chk("single_rel",   32'(a_rel),   32'd1);
        chk("single_long",  32'(a_long),  32'd0);

        // Long hold, 10 ticks
        clr_counts();
        drive(1'b1, 1'b0);
        hold_ticks(1'b1, 10);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("long_a_long", 32'(a_long), 32'd1);
        chk("long_a_rep",  32'(a_rep),  32'd3);
        chk("long_a_step", 32'(a_step), 32'd4);
        chk("long_b_long", 32'(b_long), 32'd1);
        chk("long_b_rep",  32'(b_rep),  32'd0);
        chk("long_b_step", 32'(b_step), 32'd1);

        // Release in the same cycle as the 4th tick
        clr_counts();
        drive(1'b1, 1'b0);
        hold_ticks(1'b1, 3);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        hold_ticks(1'b0, 2);
        chk("coinc_rel",  32'(a_rel),  32'd1);
        chk("coinc_long", 32'(a_long + b_long), 32'd0);
        chk("coinc_held", 32'(bus_a.o_Held), 32'd0);

        // Async reset while in REPEAT with the button held
        drive(1'b1, 1'b0);
        hold_ticks(1'b1, 6);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clr_counts();
        drive(1'b1, 1'b0);
        chk("post_rst_press", 32'(a_press), 32'd1);
        hold_ticks(1'b1, 4);
        drive(1'b1, 1'b0);
        chk("post_rst_long", 32'(a_long), 32'd1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // Minimum one-cycle press
        clr_counts();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("min_press", 32'(a_press), 32'd1);
        chk("min_rel",   32'(a_rel),   32'd1);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
